// File: rtl/xfer_rx_drain.sv
// xfer_rx_drain: drains one 4 KB rx slot from the host buffer, packs 8 words per beat
// and writes the beats to TBM with a cs/we/ack handshake before releasing the slot.
module xfer_rx_drain #(
   parameter int HDATA_WIDTH    = 32,
   parameter int MDATA_WIDTH    = 256,
   parameter int ADDRESS_WIDTH  = 32,
   parameter int UNIT_BUF_BY_4B = 1024,
   parameter int MAX_BUFQ_DEPTH = 4,
   parameter int BUF_AW         = 12
) (
   input  logic                     clock_host,
   input  logic                     reset,
   input  logic                     xfer_start,
   input  logic [ADDRESS_WIDTH-1:0] tbm_address,
   input  logic [3:0]               rx_filled,
   output logic                     buf_rd_en,
   output logic [BUF_AW-1:0]        buf_rd_addr,
   input  logic [HDATA_WIDTH-1:0]   buf_rd_data,
   output logic                     slot_release,
   output logic                     chip_select,
   output logic                     write_enable,
   output logic [ADDRESS_WIDTH-1:0] maddress,
   output logic [MDATA_WIDTH-1:0]   mdata_out,
   input  logic                     mem_ack,
   output logic                     xfer_complete,
   output logic                     busy
);
   localparam int LANES = MDATA_WIDTH / HDATA_WIDTH;
   localparam int LW    = $clog2(LANES);
   localparam int WW    = $clog2(UNIT_BUF_BY_4B);
   localparam int TW    = $clog2(MAX_BUFQ_DEPTH);
   localparam int BEATS = UNIT_BUF_BY_4B / LANES;
   localparam int BW    = $clog2(BEATS);
   localparam logic [2:0] IDLE = 3'd0, WAIT_SLOT = 3'd1, READ = 3'd2, CAP = 3'd3, WRITE = 3'd4, DONE = 3'd5;

   logic [2:0]               state_q, state_d;
   logic [TW-1:0]            tail_q, tail_d;
   logic [WW-1:0]            word_q, word_d;
   logic [BW-1:0]            beat_q, beat_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [MDATA_WIDTH-1:0]   data_q, data_d;
   logic [LW-1:0]            lane;
   logic                     cap_en;

   // Read data trails the strobe by one cycle, so it lands in the lane of the previous word index.
   assign lane   = word_q[LW-1:0] - 1'b1;
   assign cap_en = (state_q == READ && word_q[LW-1:0] != '0) || state_q == CAP;

   always_comb begin
      state_d = state_q;
      tail_d  = tail_q;
      word_d  = word_q;
      beat_d  = beat_q;
      addr_d  = addr_q;
      data_d  = data_q;
      if (cap_en) data_d[HDATA_WIDTH*lane +: HDATA_WIDTH] = buf_rd_data;
      case (state_q)
         IDLE: if (xfer_start) begin
            addr_d  = tbm_address;
            state_d = WAIT_SLOT;
         end
         WAIT_SLOT: state_d = (rx_filled != '0) ? READ : WAIT_SLOT;
         READ: begin
            word_d  = word_q + 1'b1;
            state_d = (word_q[LW-1:0] == LW'(LANES-1)) ? CAP : READ;
         end
         CAP: state_d = WRITE;
         WRITE: if (mem_ack) begin
            addr_d  = addr_q + ADDRESS_WIDTH'(MDATA_WIDTH/8);
            beat_d  = beat_q + 1'b1;
            state_d = (beat_q == BW'(BEATS-1)) ? DONE : READ;
         end
         DONE: begin
            tail_d  = (tail_q == TW'(MAX_BUFQ_DEPTH-1)) ? '0 : tail_q + 1'b1;
            word_d  = '0;
            beat_d  = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_host) begin
      if (reset) begin
         state_q <= IDLE;
         tail_q  <= '0;
         word_q  <= '0;
         beat_q  <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         tail_q  <= tail_d;
         word_q  <= word_d;
         beat_q  <= beat_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign buf_rd_en     = state_q == READ;
   assign buf_rd_addr   = {tail_q, word_q};
   assign chip_select   = state_q == WRITE;
   assign write_enable  = chip_select;
   assign maddress      = addr_q;
   assign mdata_out     = data_q;
   assign slot_release  = state_q == DONE;
   assign xfer_complete = state_q == DONE;
   assign busy          = state_q != IDLE;
endmodule

// File: doc/xfer_rx_drain.md
Name: xfer_rx_drain

Overview:
- Bottom-half stage directly downstream of the host transfer buffer.
- On command, drains one full 4 KB rx slot from the buffer's read port.
- Packs each eight 32-bit host words into one 256-bit beat.
- Writes the beats to TBM memory at consecutive addresses with a cs/we/ack handshake, then releases the slot back to the buffer.

Parameters:
- HDATA_WIDTH, 32: buffer word width.
- MDATA_WIDTH, 256: TBM beat width (8 words).
- ADDRESS_WIDTH, 32: TBM byte-address width.
- UNIT_BUF_BY_4B, 1024: words per slot.
- MAX_BUFQ_DEPTH, 4: number of slots in the rx queue.
- BUF_AW, 12: buffer word-address width (log2 of 4096).

Ports:
- clock_host  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- xfer_start  in  1  1-cycle request; accepted only in IDLE.
- tbm_address  in  ADDRESS_WIDTH  TBM start byte address, captured with xfer_start.
- rx_filled  in  4  count of full rx slots awaiting drain.
- buf_rd_en  out  1  buffer read strobe.
- buf_rd_addr  out  BUF_AW  word address = tail*UNIT_BUF_BY_4B + word index.
- buf_rd_data  in  HDATA_WIDTH  read data, valid the cycle after buf_rd_en.
- slot_release  out  1  1-cycle pulse: slot drained, buffer may reuse it.
- chip_select  out  1  TBM request.
- write_enable  out  1  TBM write qualifier (equals chip_select in this block).
- maddress  out  ADDRESS_WIDTH  TBM byte address of the current beat.
- mdata_out  out  MDATA_WIDTH  TBM write data.
- mem_ack  in  1  TBM accept; sampled only while chip_select=1.
- xfer_complete  out  1  1-cycle pulse at end of slot transfer.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (takes priority over everything, including mid-operation):
  - All outputs 0; mdata_out 0.
  - tail=0, word and beat counters 0, state IDLE.
  - No slot_release or xfer_complete is generated for an aborted transfer.
- IDLE:
  - On xfer_start: capture tbm_address into the address register and go to WAIT_SLOT.
  - xfer_start in any other state is ignored.
- WAIT_SLOT:
  - Stay while rx_filled==0.
  - When rx_filled!=0, go to READ.
- READ (8 cycles per beat):
  - buf_rd_en=1 each cycle; buf_rd_addr = tail*1024 + word_idx; word_idx increments every cycle.
  - Data from read i is captured one cycle later into lane (i mod 8), at bits [32k+31:32k] for k = i mod 8. Word 0 of a beat lands in bits [31:0].
  - After the 8th read, go to CAP.
- CAP (1 cycle):
  - buf_rd_en=0; the last lane is captured.
  - Go to WRITE with mdata_out holding the full beat.
- WRITE:
  - chip_select=write_enable=1.
  - maddress and mdata_out are held stable until mem_ack=1 is sampled. Handshake completes at that edge, including when mem_ack is high in the first WRITE cycle.
  - On completion: maddress += 32 (wraps modulo 2^ADDRESS_WIDTH); chip_select and write_enable drop next cycle.
  - If beat_cnt==127 (last of UNIT_BUF_BY_4B/8 beats), go to DONE; otherwise beat_cnt++ and go to READ.
- DONE (1 cycle):
  - slot_release=1 and xfer_complete=1.
  - tail = (tail+1) mod MAX_BUFQ_DEPTH; word_idx and beat_cnt cleared.
  - Go to IDLE.
- Latency:
  - Minimum per beat (mem_ack tied high): 10 cycles.
  - Minimum per slot: 128*10 + 1 cycles after WAIT_SLOT exits, with DONE as the final cycle.
- Ownership of rx_filled:
  - rx_filled is only sampled in WAIT_SLOT.
  - Decrementing it on slot_release is the buffer's responsibility.
- buf_rd_data is ignored in every state except READ and CAP.

Test Plan:
1. Assert reset for 3 cycles with random inputs -> all outputs 0, busy=0; xfer_start during reset is not latched.
2. Slot 0 word n = n, rx_filled=1, tbm_address=0x1000, mem_ack=1, pulse xfer_start:
   - buf_rd_addr sweeps 0..1023.
   - 128 beats; first mdata_out = {32'd7,...,32'd0} at maddress 0x1000; last beat at 0x1FE0.
   - Exactly one slot_release and one xfer_complete, in the same cycle.
3. rx_filled=0 at xfer_start, raised to 1 after 50 cycles -> busy=1, no buf_rd_en for those 50 cycles; then the first read occurs 1 cycle after WAIT_SLOT samples rx_filled!=0.
4. mem_ack delayed 5 cycles on beat 3, plus a second xfer_start pulsed mid-transfer:
   - cs/we/maddress/mdata stable for all 5 cycles.
   - The second start is ignored (only one xfer_complete).
5. Five back-to-back transfers -> first buf_rd_addr values 0, 1024, 2048, 3072, 0 (tail wraps).
6. Reset asserted in WRITE of beat 10 -> chip_select=0 at the next edge, no slot_release or xfer_complete; the next transfer reads from address 0.
